micro_fetch: RTL and testbench

//  Control-store fetch stage that feeds the microprogram sequencer. Looks up

---
 rtl/myca_pkg.sv | 40 ++++
 rtl/micro_fetch_cond_sync.sv | 23 ++
 rtl/micro_fetch.sv | 120 ++++++++++++
 tb/tb_micro_fetch.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/myca_pkg.sv
// Shared definitions for the micro_fetch control-store stage: word layout, opcodes, FSM states.
// Optional parity is enabled by defining MYCA_FETCH_PARITY_EN.
package myca_pkg;

    localparam int CTLW     = 8;
    localparam int CTL_LSB  = 0;
    localparam int DIRI_LSB = CTL_LSB + CTLW;
    localparam int DIRB_LSB = DIRI_LSB + 8;
    localparam int POL_LSB  = DIRB_LSB + 8;
    localparam int CSEL_LSB = POL_LSB + 1;
    localparam int CSEL_W   = 2;
    localparam int OPC_LSB  = CSEL_LSB + CSEL_W;
    localparam int OPC_W    = 3;
    // Microinstruction payload width; the MIR never holds the parity bit.
    localparam int BASE_W   = OPC_LSB + OPC_W;

`ifdef MYCA_FETCH_PARITY_EN
    localparam int WW = BASE_W + 1;
`else
    localparam int WW = BASE_W;
`endif

    localparam logic [OPC_W-1:0] OPC_CONT = 3'd0;
    localparam logic [OPC_W-1:0] OPC_JUMP = 3'd1;
    localparam logic [OPC_W-1:0] OPC_CJMP = 3'd2;
    localparam logic [OPC_W-1:0] OPC_MAP  = 3'd3;
    localparam logic [OPC_W-1:0] OPC_CALL = 3'd4;
    localparam logic [OPC_W-1:0] OPC_RET  = 3'd5;
    localparam logic [OPC_W-1:0] OPC_LOOP = 3'd6;
    localparam logic [OPC_W-1:0] OPC_PUSH = 3'd7;

    localparam logic [BASE_W-1:0] NOP_WORD = '0;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

endpackage

// File: rtl/micro_fetch_cond_sync.sv
// Bank of two-flop synchronisers for the asynchronous condition flags.
module cond_sync #(
    parameter int N = 4
) (
    input  logic         ck,
    input  logic         rst,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] meta;

    always_ff @(posedge ck) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/micro_fetch.sv
// Control-store fetch stage: store lookup into the MIR, run/halt/step control, programming port.
// Define MYCA_FETCH_PARITY_EN to append and check an even-parity bit on every stored word.
module micro_fetch
    import myca_pkg::*;
#(
    parameter int AW    = 8,
    parameter int NCOND = 4
) (
    input  logic             ck,
    input  logic             rst,
    input  logic [AW-1:0]    pc_in,
    input  logic [NCOND-1:0] cond,
    input  logic             run,
    input  logic             halt,
    input  logic             step,
    input  logic             prog_we,
    input  logic [AW-1:0]    prog_addr,
    input  logic [WW-1:0]    prog_data,
    output logic [2:0]       opc,
    output logic             x,
    output logic [7:0]       DIRB,
    output logic [7:0]       DIRI,
    output logic [CTLW-1:0]  ctl,
    output logic             seq_en,
    output logic             halted,
    output logic             wr_rej,
    output logic             perr,
    output state_t           dbg_state
);

    // run/halt/step and prog_we are single-cycle pulses sampled on the ck edge;
    // there is no back-pressure, a refused write is only reported through wr_rej.
    state_t            state, state_nxt;
    logic [WW-1:0]     store [2**AW];
    logic [WW-1:0]     rd_word;
    logic [BASE_W-1:0] mir;
    logic [NCOND-1:0]  cond_s;
    logic              fetch;
    logic              par_err;
    logic              sel_bit;

    assign fetch   = (state == ST_RUN) || (state == ST_STEP);
    assign rd_word = store[pc_in];

`ifdef MYCA_FETCH_PARITY_EN
    assign par_err = fetch && (^rd_word);

    always_ff @(posedge ck) begin
        if (rst)
            perr <= 1'b0;
        else if (par_err)
            perr <= 1'b1;
    end
`else
    assign par_err = 1'b0;
    assign perr    = 1'b0;
`endif

    always_ff @(posedge ck) begin
        if (prog_we && (state == ST_HALT))
            store[prog_addr] <= prog_data;
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state  <= ST_HALT;
            mir    <= NOP_WORD;
            wr_rej <= 1'b0;
        end else begin
            state  <= state_nxt;
            wr_rej <= prog_we && (state != ST_HALT);
            if (fetch)
                mir <= par_err ? NOP_WORD : rd_word[BASE_W-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_HALT: begin
                if (halt)
                    state_nxt = ST_HALT;
                else if (step)
                    state_nxt = ST_STEP;
                else if (run)
                    state_nxt = ST_RUN;
            end
            ST_RUN:  if (halt) state_nxt = ST_HALT;
            ST_STEP: state_nxt = ST_HALT;
            default: state_nxt = ST_HALT;
        endcase
        if (par_err)
            state_nxt = ST_HALT;
    end

    cond_sync #(.N(NCOND)) u_sync (
        .ck  (ck),
        .rst (rst),
        .d   (cond),
        .q   (cond_s)
    );

    // Select values with no matching condition input read as constant 0.
    always_comb begin
        sel_bit = 1'b0;
        for (int i = 0; i < NCOND; i++)
            if (mir[CSEL_LSB +: CSEL_W] == CSEL_W'(i))
                sel_bit = cond_s[i];
    end

    assign x         = sel_bit ^ mir[POL_LSB];
    assign opc       = mir[OPC_LSB +: OPC_W];
    assign DIRB      = mir[DIRB_LSB +: 8];
    assign DIRI      = mir[DIRI_LSB +: 8];
    assign ctl       = mir[CTL_LSB +: CTLW];
    assign seq_en    = fetch;
    assign halted    = (state == ST_HALT);
    assign dbg_state = state;

endmodule

// File: tb/tb_micro_fetch.sv
// Directed bench for micro_fetch: reset, fetch, condition select, step/halt, refused writes, parity.
module tb_micro_fetch;
    import myca_pkg::*;

    localparam int AW    = 8;
    localparam int NCOND = 3;

    logic             ck = 1'b0;
    logic             rst;
    logic [AW-1:0]    pc_in;
    logic [NCOND-1:0] cond;
    logic             run, halt, step, prog_we;
    logic [AW-1:0]    prog_addr;
    logic [WW-1:0]    prog_data;
    logic [2:0]       opc;
    logic             x;
    logic [7:0]       DIRB, DIRI;
    logic [CTLW-1:0]  ctl;
    logic             seq_en, halted, wr_rej, perr;
    state_t           dbg_state;

    int vectors = 0;
    int fails   = 0;

    micro_fetch #(.AW(AW), .NCOND(NCOND)) dut (
        .ck(ck), .rst(rst), .pc_in(pc_in), .cond(cond), .run(run), .halt(halt),
        .step(step), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .opc(opc), .x(x), .DIRB(DIRB), .DIRI(DIRI), .ctl(ctl), .seq_en(seq_en),
        .halted(halted), .wr_rej(wr_rej), .perr(perr), .dbg_state(dbg_state)
    );

    always #5 ck = ~ck;

    // Layout from LSB: ctl, DIRI, DIRB, pol, csel, opc; optional even-parity MSB.
    function automatic logic [WW-1:0] mk_word(input logic [2:0] o, input logic [1:0] cs,
                                              input logic p, input logic [7:0] b,
                                              input logic [7:0] i, input logic [7:0] c,
                                              input logic bad_par);
        logic [29:0] w;
        w = {o, cs, p, b, i, c};
`ifdef MYCA_FETCH_PARITY_EN
        return {(^w) ^ bad_par, w};
`else
        return (bad_par) ? w : w;
`endif
    endfunction

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic prog(input logic [AW-1:0] a, input logic [WW-1:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pc_in = '0; cond = '0; run = 0; halt = 0; step = 0;
        prog_we = 0; prog_addr = '0; prog_data = '0;
        tick(); tick();
        rst = 1'b0;

        check("rst_halted", halted, 1);
        check("rst_seq_en", seq_en, 0);
        check("rst_opc", opc, 0);
        check("rst_dirb", DIRB, 0);
        check("rst_diri", DIRI, 0);
        check("rst_ctl", ctl, 0);
        check("rst_x", x, 0);
        check("rst_wr_rej", wr_rej, 0);
        check("rst_perr", perr, 0);
        check("rst_state", dbg_state, 0);

        prog(8'h05, mk_word(3'd3, 2'd1, 1'b0, 8'h20, 8'h40, 8'hA5, 1'b0));
        check("halt_write_no_rej", wr_rej, 0);
        prog(8'h06, mk_word(3'd1, 2'd1, 1'b1, 8'h11, 8'h22, 8'h33, 1'b0));
        prog(8'h07, mk_word(3'd2, 2'd3, 1'b1, 8'h44, 8'h55, 8'h66, 1'b0));
        prog(8'h08, mk_word(3'd4, 2'd3, 1'b0, 8'h77, 8'h88, 8'h99, 1'b0));
        prog(8'h09, mk_word(3'd5, 2'd0, 1'b0, 8'h99, 8'h5A, 8'h3C, 1'b0));

        pc_in = 8'h05; run = 1'b1;
        tick();
        run = 1'b0;
        check("run_entered", halted, 0);
        check("run_seq_en", seq_en, 1);
        check("run_opc_not_yet", opc, 0);
        tick();
        check("fetch_opc", opc, 3);
        check("fetch_dirb", DIRB, 8'h20);
        check("fetch_diri", DIRI, 8'h40);
        check("fetch_ctl", ctl, 8'hA5);
        check("fetch_seq_en", seq_en, 1);
        check("fetch_x_pol0", x, 0);

        pc_in = 8'h06;
        tick();
        check("pol1_x", x, 1);
        cond = 3'b010;
        tick();
        check("sync_x_1cyc", x, 1);
        tick();
        check("sync_x_2cyc", x, 0);
        pc_in = 8'h07;
        tick();
        check("csel3_pol1", x, 1);
        pc_in = 8'h08;
        tick();
        check("csel3_pol0", x, 0);

        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("halt_halted", halted, 1);
        check("halt_seq_en", seq_en, 0);
        pc_in = 8'h05;
        tick(); tick();
        check("halt_mir_hold", opc, 4);

        pc_in = 8'h06; step = 1'b1;
        tick();
        step = 1'b0;
        check("step_seq_en", seq_en, 1);
        check("step_opc_not_yet", opc, 4);
        tick();
        check("step_opc", opc, 1);
        check("step_back_halted", halted, 1);
        check("step_seq_en_off", seq_en, 0);
        pc_in = 8'h05;
        tick();
        check("step_single_load", opc, 1);

        halt = 1'b1; run = 1'b1;
        tick();
        halt = 1'b0; run = 1'b0;
        check("halt_beats_run", halted, 1);
        check("halt_beats_run_en", seq_en, 0);

        run = 1'b1;
        tick();
        run = 1'b0;
        prog(8'h09, mk_word(3'd6, 2'd0, 1'b0, 8'hEE, 8'hDD, 8'hCC, 1'b0));
        check("run_write_rej", wr_rej, 1);
        tick();
        check("rej_one_cycle", wr_rej, 0);
        pc_in = 8'h09;
        tick();
        check("rej_old_opc", opc, 5);
        check("rej_old_dirb", DIRB, 8'h99);

        halt = 1'b1;
        tick();
        halt = 1'b0;
        prog(8'h09, mk_word(3'd6, 2'd0, 1'b0, 8'hEE, 8'hDD, 8'hCC, 1'b0));
        check("halt_write_ok", wr_rej, 0);
        check("mir_not_rewritten", DIRB, 8'h99);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        check("new_word_fetched", DIRB, 8'hEE);
        check("new_word_opc", opc, 6);

        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrun_rst_halted", halted, 1);
        check("midrun_rst_opc", opc, 0);
        check("midrun_rst_dirb", DIRB, 0);
        check("midrun_rst_seq_en", seq_en, 0);

`ifdef MYCA_FETCH_PARITY_EN
        prog(8'h0A, mk_word(3'd7, 2'd0, 1'b0, 8'h12, 8'h34, 8'h56, 1'b1));
        pc_in = 8'h05; run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        check("par_good_fetch", opc, 3);
        check("par_good_perr", perr, 0);
        pc_in = 8'h0A;
        tick();
        check("par_bad_opc", opc, 0);
        check("par_bad_ctl", ctl, 0);
        check("par_bad_halted", halted, 1);
        check("par_bad_perr", perr, 1);
        tick(); tick();
        check("par_perr_sticky", perr, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("par_perr_cleared", perr, 0);
`else
        pc_in = 8'h05; run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        check("nopar_fetch", opc, 3);
        check("nopar_perr", perr, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
